// File: rtl/glb_stream_scheduler.sv
// Round-robin scheduler sharing one GLB stream channel among NUM_STREAMS write sources.
// A grant is held for up to BURST_LEN words or until a segment-end word; output is a single register.
module glb_stream_scheduler #(
  parameter int NUM_STREAMS = 4,
  parameter int DATA_WIDTH  = 17,
  parameter int BURST_LEN   = 8,
  localparam int ID_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_STREAMS-1:0]            stream_en,
  input  logic [NUM_STREAMS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_STREAMS-1:0]            in_valid,
  output logic [NUM_STREAMS-1:0]            in_ready,
  input  logic [NUM_STREAMS-1:0]            in_done,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [ID_W-1:0]                   out_id,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              grant_active,
  output logic                              all_done
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        sel_q, sel_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [7:0]             burst_q, burst_d;
  logic [NUM_STREAMS-1:0] eligible;
  logic [ID_W-1:0]        pick;
  logic                   pick_vld;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_valid, sel_done, sel_en;
  logic                   sel_ready, xfer;

  assign eligible     = stream_en & in_valid & ~in_done;
  assign grant_active = (state_q == GRANT);

  // First eligible index after the rr pointer, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (!pick_vld && eligible[i] && (((int'(rr_q) + k) % NUM_STREAMS) == i)) begin
          pick     = ID_W'(i);
          pick_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_done  = 1'b0;
    sel_en    = 1'b0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (sel_q == ID_W'(i)) begin
        sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = in_valid[i];
        sel_done  = in_done[i];
        sel_en    = stream_en[i];
      end
    end
  end

  // Ready is withheld during rst/flush so no word is accepted that would be dropped.
  assign sel_ready = !rst && !flush && (state_q == GRANT) && (!out_valid || out_ready);
  assign xfer      = sel_valid && sel_ready;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (sel_q == ID_W'(i)) in_ready[i] = sel_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d   = pick;
          rr_d    = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (sel_data[DATA_WIDTH-1] || (burst_q == 8'(BURST_LEN - 1))) state_d = IDLE;
          else burst_d = burst_q + 8'd1;
        end else if (!sel_valid && (sel_done || !sel_en)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      burst_d = '0;
      rr_d    = ID_W'(NUM_STREAMS - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= ID_W'(NUM_STREAMS - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_id    <= sel_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) all_done <= 1'b0;
    else     all_done <= !flush && (&(~stream_en | in_done)) && !out_valid && (state_q == IDLE);
  end

endmodule

// File: tb/tb_glb_stream_scheduler.sv
// Directed bench for glb_stream_scheduler: source queues feed the DUT, accepted words go to a
// scoreboard queue and are compared when they leave the output register.
module tb_glb_stream_scheduler;
  localparam int N = 4;
  localparam int W = 17;

  logic           clk = 1'b0;
  logic           rst, flush;
  logic [N-1:0]   stream_en, in_valid, in_ready, in_done;
  logic [N*W-1:0] in_data;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_valid, out_ready, grant_active, all_done;

  always #5 clk = ~clk;

  glb_stream_scheduler #(.NUM_STREAMS(N), .DATA_WIDTH(W), .BURST_LEN(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stream_en(stream_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_done(in_done),
    .out_data(out_data), .out_id(out_id), .out_valid(out_valid), .out_ready(out_ready),
    .grant_active(grant_active), .all_done(all_done)
  );

  logic [W-1:0] src_q [N][$];
  logic [18:0]  exp_q [$];
  logic [1:0]   log_id [$];
  logic [W-1:0] log_data [$];
  int           log_cyc [$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  logic         bp_chk = 1'b0;
  logic [W-1:0] hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]       = (src_q[i].size() != 0);
      in_data[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
  endtask

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic clear_logs();
    log_id.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  // One clock: sample at negedge, account handshakes, advance, redrive sources.
  task automatic cycle();
    logic [18:0] e;
    @(negedge clk);
    chk("ready_onehot", ($countones(in_ready) <= 1), 1);
    if (bp_chk) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_stable", out_data, hold);
    end
    if (rst || flush) begin
      chk("ready_rst_flush", in_ready, 0);
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("out_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e[16:0]);
          chk("sb_id", out_id, e[18:17]);
        end
        log_id.push_back(out_id);
        log_data.push_back(out_data);
        log_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          exp_q.push_back({2'(i), src_q[i][0]});
          void'(src_q[i].pop_front());
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic run_drain(input int max_cyc);
    int n = 0;
    while (!(srcs_empty() && exp_q.size() == 0 && !out_valid) && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", (n < max_cyc), 1);
  endtask

  task automatic do_reset(input logic [N-1:0] en);
    for (int i = 0; i < N; i++) src_q[i].delete();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_done = '0; stream_en = en;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    exp_q.delete();
    clear_logs();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_done = '0; stream_en = '0;
    in_valid = '0; in_data = '0;

    // Reset values and single-source segment.
    do_reset(4'b0001);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_grant", grant_active, 0);
    chk("rst_all_done", all_done, 0);
    src_q[0].push_back(17'h00001);
    src_q[0].push_back(17'h00002);
    src_q[0].push_back(17'h10003);
    drive();
    run_drain(50);
    chk("t1_count", log_data.size(), 3);
    if (log_data.size() == 3) begin
      chk("t1_w0", log_data[0], 17'h00001);
      chk("t1_w1", log_data[1], 17'h00002);
      chk("t1_w2", log_data[2], 17'h10003);
      chk("t1_id2", log_id[2], 0);
    end
    chk("t1_idle", grant_active, 0);
    chk("t1_not_done", all_done, 0);
    in_done = 4'b0001;
    cycle();
    chk("t1_all_done", all_done, 1);

    // All four sources continuously valid: 8-word bursts, round robin, one idle cycle between.
    do_reset(4'b1111);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) src_q[i].push_back(17'((i << 8) | k));
    drive();
    run_drain(300);
    chk("t2_count", log_id.size(), 64);
    if (log_id.size() == 64) begin
      for (int k = 0; k < 64; k++) chk("t2_burst_id", log_id[k], (k / 8) % 4);
      for (int k = 1; k < 64; k++)
        chk("t2_gap", log_cyc[k] - log_cyc[k-1], ((k % 8) == 0) ? 2 : 1);
    end

    // Back-pressure mid-burst.
    do_reset(4'b0010);
    for (int k = 0; k < 6; k++) src_q[1].push_back(17'(17'h100 + k));
    drive();
    repeat (3) cycle();
    out_ready = 1'b0;
    hold = out_data;
    bp_chk = 1'b1;
    repeat (5) cycle();
    bp_chk = 1'b0;
    out_ready = 1'b1;
    run_drain(50);
    chk("t3_count", log_data.size(), 6);
    if (log_data.size() == 6) chk("t3_last", log_data[5], 17'h105);

    // Segment end on first word of source 2; next grant follows the rr pointer to 3.
    do_reset(4'b1110);
    src_q[1].push_back(17'h10001);
    src_q[1].push_back(17'h00011);
    src_q[1].push_back(17'h10012);
    src_q[2].push_back(17'h10005);
    src_q[3].push_back(17'h00031);
    src_q[3].push_back(17'h10032);
    drive();
    run_drain(60);
    chk("t4_count", log_id.size(), 6);
    if (log_id.size() == 6) begin
      chk("t4_id0", log_id[0], 1);
      chk("t4_id1", log_id[1], 2);
      chk("t4_d1", log_data[1], 17'h10005);
      chk("t4_id2", log_id[2], 3);
      chk("t4_id3", log_id[3], 3);
      chk("t4_id4", log_id[4], 1);
      chk("t4_d4", log_data[4], 17'h00011);
    end

    // Flush while source 1 holds the grant with a pending output word.
    do_reset(4'b0010);
    for (int k = 0; k < 20; k++) src_q[1].push_back(17'(17'h200 + k));
    drive();
    repeat (4) cycle();
    out_ready = 1'b0;
    cycle();
    chk("t5_pre_valid", out_valid, 1);
    chk("t5_pre_grant", grant_active, 1);
    flush = 1'b1;
    stream_en = 4'b0011;
    src_q[0].push_back(17'h10040);
    drive();
    cycle();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_grant", grant_active, 0);
    clear_logs();
    run_drain(200);
    chk("t5_nonempty", (log_id.size() >= 2), 1);
    if (log_id.size() >= 2) begin
      chk("t5_first_id", log_id[0], 0);
      chk("t5_first_data", log_data[0], 17'h10040);
      chk("t5_second_id", log_id[1], 1);
    end

    // Reset during a grant.
    do_reset(4'b0100);
    for (int k = 0; k < 20; k++) src_q[2].push_back(17'(17'h300 + k));
    drive();
    repeat (4) cycle();
    chk("t6_pre_grant", grant_active, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    stream_en = 4'b0101;
    src_q[0].push_back(17'h00050);
    src_q[0].push_back(17'h10051);
    drive();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_id", out_id, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_grant", grant_active, 0);
    chk("t6_all_done", all_done, 0);
    clear_logs();
    run_drain(200);
    chk("t6_nonempty", (log_id.size() >= 3), 1);
    if (log_id.size() >= 3) begin
      chk("t6_id0", log_id[0], 0);
      chk("t6_id1", log_id[1], 0);
      chk("t6_d1", log_data[1], 17'h10051);
      chk("t6_id2", log_id[2], 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/glb_stream_scheduler.md
Name: glb_stream_scheduler

Overview:
- Shares one 17-bit valid/ready GLB stream channel between NUM_STREAMS GLB write sources.
- Uses round-robin arbitration. Once a source is granted, the grant is held for a burst or until the end of a segment.
- Each output word is tagged with its source id, through a single output register.
- Sits between the per-tile GLB write sources and the shared fabric input port. It also reports when all enabled sources have finished after a flush.

Parameters:
- NUM_STREAMS, 4: number of requesting sources (2..16).
- DATA_WIDTH, 17: word width. The MSB (bit DATA_WIDTH-1) is the segment-end/stop-token flag.
- BURST_LEN, 8: maximum words forwarded per grant (1..255).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous; aborts the current grant, resets arbitration state
- stream_en  input  NUM_STREAMS  per-source enable mask
- in_data  input  NUM_STREAMS*DATA_WIDTH  source words, packed (source i at [i*DATA_WIDTH +: DATA_WIDTH])
- in_valid  input  NUM_STREAMS  source valid
- in_ready  output  NUM_STREAMS  source ready
- in_done  input  NUM_STREAMS  source has finished all transfers (level)
- out_data  output  DATA_WIDTH  forwarded word
- out_id  output  max(1,$clog2(NUM_STREAMS))  source index of out_data
- out_valid  output  1  output word valid
- out_ready  input  1  downstream ready
- grant_active  output  1  a source currently holds the grant
- all_done  output  1  every enabled source is done and the output is empty

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_id=0, in_ready=0, grant_active=0, all_done=0.
  - rr pointer=NUM_STREAMS-1, so source 0 has highest priority first.
  - burst count=0, state=IDLE.
  - Reset mid-burst drops the register contents with no handshake.
- Eligible source i: stream_en[i] && in_valid[i] && !in_done[i].
- State IDLE:
  - If any source is eligible, pick the first eligible index after the rr pointer (wrapping).
  - Register it as sel, set rr pointer=sel, burst count=0, go to GRANT.
  - The decision costs exactly one cycle; in_ready is 0 for all sources in IDLE.
- State GRANT:
  - in_ready[sel] = (!out_valid || out_ready). All other in_ready bits are 0. in_ready is combinational from state and out_ready.
  - Transfer on a source = in_valid[sel] && in_ready[sel]. It loads out_data=in_data[sel], out_id=sel, out_valid=1 on the next edge. Latency is 1 cycle.
  - If out_valid && out_ready and no transfer occurs, out_valid clears to 0. Back-to-back transfers give one word per cycle.
  - Release to IDLE after a transfer when either:
    - the transferred word's MSB=1 (segment end), or
    - burst count reaches BURST_LEN-1 (BURST_LEN words sent).
  - Also release when in_done[sel]=1 && in_valid[sel]=0, or when stream_en[sel]=0 while in_valid[sel]=0.
  - If both segment end and burst limit occur on the same word: a single release.
  - The output register keeps draining independently of state.
- grant_active = (state==GRANT).
- flush=1 at an edge: state=IDLE, burst count=0, rr pointer=NUM_STREAMS-1, out_valid=0.
  - Words not yet accepted are discarded.
  - in_ready=0 in the cycle flush is high.
  - rst has priority over flush.
- all_done is registered. It is 1 when every source with stream_en=1 has in_done=1, and out_valid=0, and state=IDLE. It is 0 while flush=1.
  - stream_en all zero gives all_done=1 after one cycle, provided no flush.
- Word contents pass through unmodified; no width conversion.

Test Plan:
- Single source 0 enabled with 3 words 0x00001, 0x00002, 0x10003 and out_ready=1:
  - out_data sequence 0x00001, 0x00002, 0x10003 with out_id=0.
  - Then return to IDLE; all_done=1 one cycle after in_done[0] rises.
- All 4 sources continuously valid, no segment ends, BURST_LEN=8:
  - Bursts of exactly 8 words in order id 0,1,2,3,0.
  - One idle cycle between bursts.
- Back-pressure: out_ready held low for 5 cycles mid-burst:
  - out_data is stable and in_ready[sel]=0 while out_valid=1.
  - No word is lost or duplicated; the total count matches.
- Source 2 sends 0x10005 as its first word while sources 1 and 3 are valid:
  - Grant releases after 1 word.
  - The next grant goes to 3, not 1, because the rr pointer was at 2.
- flush asserted while source 1 is mid-burst with out_valid=1:
  - Next cycle out_valid=0 and grant_active=0.
  - The next grant goes to source 0.
- rst asserted for one cycle during GRANT:
  - All outputs are 0 on the following cycle.
  - Arbitration restarts from source 0.
